// File: rtl/key_schedule_ctrl_if.sv
// Key load / round-key read bundle for key_schedule_ctrl.
// master: key source + round readers; slave: the scheduler.
interface key_schedule_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              key_valid;
  logic [127:0]      key_in;
  logic              key_ready;
  logic              keys_valid;
  logic              sched_done;
  logic              rk_rd_en;
  logic [ADDR_W-1:0] rk_addr;
  logic [127:0]      rk_data;
  logic              rk_rd_valid;
  logic              rk_err;

  modport master (
    output key_valid,
    output key_in,
    output rk_rd_en,
    output rk_addr,
    input  key_ready,
    input  keys_valid,
    input  sched_done,
    input  rk_data,
    input  rk_rd_valid,
    input  rk_err
  );

  modport slave (
    input  key_valid,
    input  key_in,
    input  rk_rd_en,
    input  rk_addr,
    output key_ready,
    output keys_valid,
    output sched_done,
    output rk_data,
    output rk_rd_valid,
    output rk_err
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: one round key per clock into a
// register file. Ports: clk, reset (sync, high), bus (slave modport).
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ADDR_W     = 4
) (
  input logic               clk,
  input logic               reset,
  key_schedule_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [3:0]        LAST  = 4'(NUM_ROUNDS);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(
    input logic [7:0] i
  );
    logic [7:0] r;
    r = 8'h00;
    case (i)
      8'd1:    r = 8'h01;
      8'd2:    r = 8'h02;
      8'd3:    r = 8'h04;
      8'd4:    r = 8'h08;
      8'd5:    r = 8'h10;
      8'd6:    r = 8'h20;
      8'd7:    r = 8'h40;
      8'd8:    r = 8'h80;
      8'd9:    r = 8'h1b;
      8'd10:   r = 8'h36;
      8'd11:   r = 8'h6c;
      8'd12:   r = 8'hd8;
      8'd13:   r = 8'hab;
      8'd14:   r = 8'h4d;
      8'd15:   r = 8'h9a;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  // One AES-128 expansion round: four new words from the
  // previous round key and the round constant index.
  function automatic logic [127:0] expandkey(
    input logic [127:0] k,
    input logic [7:0]   ri
  );
    logic [31:0] w0, w1, w2, w3, t;
    logic [31:0] n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]})
       ^ {rcon(ri), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t       state, state_n;
  logic [3:0]   cnt;
  logic [127:0] prev;
  logic [127:0] next_rk;
  logic [127:0] rk [NUM_ROUNDS+1];
  logic         load;
  logic         step;
  logic         last;
  logic         addr_ok;

  assign next_rk = expandkey(prev, {4'h0, cnt});
  assign last    = (cnt == LAST);
  assign addr_ok = (bus.rk_addr <= MAX_A);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    load           = 1'b0;
    step           = 1'b0;
    bus.key_ready  = 1'b0;
    bus.keys_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          load    = 1'b1;
          state_n = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (last) state_n = READY;
      end
      READY: begin
        bus.key_ready  = 1'b1;
        bus.keys_valid = 1'b1;
        if (bus.key_valid) begin
          load    = 1'b1;
          state_n = EXPAND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // cnt parks at NUM_ROUNDS once the last key is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= 4'd0;
      prev           <= '0;
      bus.sched_done <= 1'b0;
    end else begin
      bus.sched_done <= step && last;
      if (load) begin
        prev <= bus.key_in;
        cnt  <= 4'd1;
      end else if (step) begin
        prev <= next_rk;
        cnt  <= last ? cnt : cnt + 4'd1;
      end
    end
  end

  // Contents are masked by keys_valid, so no reset.
  always_ff @(posedge clk) begin
    if (load)      rk[0]   <= bus.key_in;
    else if (step) rk[cnt] <= next_rk;
  end

  // keys_valid is the pre-edge value, so a read that coincides
  // with a new key load still returns the old schedule.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rk_rd_valid <= 1'b0;
      bus.rk_err      <= 1'b0;
      bus.rk_data     <= '0;
    end else begin
      bus.rk_rd_valid <= bus.rk_rd_en;
      if (bus.rk_rd_en) begin
        if (bus.keys_valid && addr_ok) begin
          bus.rk_data <= rk[bus.rk_addr];
          bus.rk_err  <= 1'b0;
        end else begin
          bus.rk_data <= '0;
          bus.rk_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl against an arithmetic AES model.
// Directed sequence with random keys and read addresses.
module tb_key_schedule_ctrl;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] mrk [0:NR];

  always #5 clk = ~clk;

  key_schedule_ctrl_if #(.ADDR_W(4)) bus ();

  key_schedule_ctrl #(
    .NUM_ROUNDS(NR),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int         n
  );
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from the field inverse plus the affine map.
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
            ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Standard word recurrence w[i] over the whole schedule.
  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  r;
    for (int i = 0; i < 4; i++)
      w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        r = 8'h01;
        for (int j = 1; j < i/4; j++) r = xt(r);
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]],
             sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {r, 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++)
      mrk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic rd(
    input int           a,
    input string        tag,
    input logic [127:0] ed,
    input logic         ee
  );
    bus.rk_rd_en = 1'b1;
    bus.rk_addr  = 4'(a);
    tick;
    bus.rk_rd_en = 1'b0;
    chk({tag, "_v"}, bus.rk_rd_valid, 1'b1);
    chk({tag, "_d"}, bus.rk_data, ed);
    chk({tag, "_e"}, bus.rk_err, ee);
  endtask

  task automatic rd_rand(input string tag, input int n);
    int a;
    for (int j = 0; j < n; j++) begin
      a = $urandom_range(0, 15);
      if (a <= NR) rd(a, tag, mrk[a], 1'b0);
      else         rd(a, tag, 128'h0, 1'b1);
    end
  endtask

  // Called right after the accepting edge.
  task automatic sched(input string tag);
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    chk({tag, "_busy"}, bus.key_ready, 1'b0);
    for (int i = 1; i <= NR + 4; i++) begin
      tick;
      if (bus.sched_done) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == NR - 1)
        chk({tag, "_kv_lo"}, bus.keys_valid, 1'b0);
      if (i == NR)
        chk({tag, "_kv_hi"}, bus.keys_valid, 1'b1);
    end
    chk({tag, "_lat"}, first, NR);
    chk({tag, "_pulses"}, pulses, 1);
  endtask

  initial begin
    logic [127:0] fips;
    logic [127:0] ka;
    logic [127:0] kb;
    int first;
    int pulses;
    int hits;
    int e;
    int sel;
    logic acc_now;
    int acc [$];

    fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build_sbox();

    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_rd_en  = 1'b0;
    bus.rk_addr   = '0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_key_ready", bus.key_ready, 1'b1);
    chk("rst_keys_valid", bus.keys_valid, 1'b0);
    chk("rst_sched_done", bus.sched_done, 1'b0);
    chk("rst_rd_valid", bus.rk_rd_valid, 1'b0);
    chk("rst_err", bus.rk_err, 1'b0);
    chk("rst_data", bus.rk_data, 128'h0);

    // 1: FIPS-197 schedule
    model(fips);
    bus.key_in    = fips;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    sched("t1");
    rd(1, "t1_rk1", 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd(10, "t1_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // 2: full read sweep and out-of-range reads
    for (int a = 0; a <= NR; a++)
      rd(a, "t2_rd", mrk[a], 1'b0);
    tick;
    chk("t2_rdv_low", bus.rk_rd_valid, 1'b0);
    chk("t2_hold", bus.rk_data, mrk[NR]);
    rd(11, "t2_a11", 128'h0, 1'b1);
    rd(15, "t2_a15", 128'h0, 1'b1);

    // 3: reads and a stray key during EXPAND
    bus.key_in    = fips;
    bus.key_valid = 1'b1;
    tick;
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= NR + 4; i++) begin
      if (i <= 6) begin
        bus.key_valid = 1'b1;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        bus.rk_rd_en = 1'b1;
        bus.rk_addr  = 4'($urandom_range(0, NR));
      end else begin
        bus.key_valid = 1'b0;
        bus.rk_rd_en  = 1'b0;
      end
      tick;
      if (i <= 6) begin
        chk("t3_err", bus.rk_err, 1'b1);
        chk("t3_rdv", bus.rk_rd_valid, 1'b1);
        chk("t3_data", bus.rk_data, 128'h0);
        chk("t3_busy", bus.key_ready, 1'b0);
      end
      if (bus.sched_done) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("t3_lat", first, NR);
    chk("t3_pulses", pulses, 1);
    for (int a = 0; a <= NR; a++)
      rd(a, "t3_rd", mrk[a], 1'b0);

    // 4: new key in READY with a same-cycle read
    bus.key_in    = '0;
    bus.key_valid = 1'b1;
    bus.rk_rd_en  = 1'b1;
    bus.rk_addr   = 4'd10;
    tick;
    bus.key_valid = 1'b0;
    bus.rk_rd_en  = 1'b0;
    chk("t4_old_rk10", bus.rk_data,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("t4_err", bus.rk_err, 1'b0);
    chk("t4_kv_drop", bus.keys_valid, 1'b0);
    sched("t4");
    model(128'h0);
    rd(10, "t4_new_rk10",
       128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0);
    rd_rand("t4_rnd", 6);

    // 5: reset during EXPAND
    ka = {$urandom, $urandom, $urandom, $urandom};
    bus.key_in    = ka;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_ready", bus.key_ready, 1'b1);
    chk("t5_kv", bus.keys_valid, 1'b0);
    chk("t5_done", bus.sched_done, 1'b0);
    hits = 0;
    for (int i = 0; i < NR + 4; i++) begin
      tick;
      if (bus.sched_done || bus.keys_valid) hits++;
    end
    chk("t5_no_valid", hits, 0);
    rd(3, "t5_idle_rd", 128'h0, 1'b1);
    model(fips);
    bus.key_in    = fips;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    sched("t5");
    rd(10, "t5_rk10",
       128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd_rand("t5_rnd", 6);

    // 6: key_valid held high, alternating keys
    ka  = {$urandom, $urandom, $urandom, $urandom};
    kb  = {$urandom, $urandom, $urandom, $urandom};
    sel = 0;
    e   = 0;
    bus.key_in    = ka;
    bus.key_valid = 1'b1;
    while (acc.size() < 3 && e < 60) begin
      acc_now = bus.key_ready;
      tick;
      e++;
      if (acc_now) begin
        acc.push_back(e);
        sel = 1 - sel;
        bus.key_in = (sel != 0) ? kb : ka;
      end
    end
    bus.key_valid = 1'b0;
    chk("t6_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("t6_gap1", acc[1] - acc[0], NR + 1);
      chk("t6_gap2", acc[2] - acc[1], NR + 1);
    end
    sched("t6");
    model(ka);
    rd(0, "t6_rk0", ka, 1'b0);
    rd_rand("t6_rnd", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
